// File: rtl/pkt_defs_pkg.sv
// Shared widths, header layout, FSM encoding and header helper functions for the packet header parser.
// Build option PKT_HDR_CHECKSUM_EN: header grows to 8 bytes with a trailing 16-bit XOR checksum.
package pkt_defs_pkg;

    localparam int ADDR_WIDTH  = 10;
    localparam int MEM_WIDTH   = 8;
    localparam int WORD_WIDTH  = 16;
    localparam int MAX_PKT_LEN = 1024;
    localparam int IDX_WIDTH   = 3;

    localparam logic [IDX_WIDTH-1:0] SRC_OFS = 3'd0;
    localparam logic [IDX_WIDTH-1:0] DST_OFS = 3'd2;
    localparam logic [IDX_WIDTH-1:0] LEN_OFS = 3'd4;

`ifdef PKT_HDR_CHECKSUM_EN
    localparam int HDR_BYTES = 8;
`else
    localparam int HDR_BYTES = 6;
`endif

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(HDR_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic len_invalid(input logic [WORD_WIDTH-1:0] len);
        return (len == {WORD_WIDTH{1'b0}}) || (len > WORD_WIDTH'(MAX_PKT_LEN));
    endfunction

    // Even-index bytes fold into the high lane, odd-index bytes into the low lane.
    function automatic logic [WORD_WIDTH-1:0] csum_fold(
        input logic [WORD_WIDTH-1:0] acc,
        input logic [MEM_WIDTH-1:0]  data,
        input logic                  odd
    );
        logic [WORD_WIDTH-1:0] lane;
        if (odd) begin
            lane = {{(WORD_WIDTH-MEM_WIDTH){1'b0}}, data};
        end else begin
            lane = {data, {(WORD_WIDTH-MEM_WIDTH){1'b0}}};
        end
        return acc ^ lane;
    endfunction

endpackage

// File: rtl/pkt_header_parser_if.sv
// Handshake and packet-memory bus of the header parser; slave is the parser side.
interface pkt_header_parser_if;
    import pkt_defs_pkg::*;

    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [MEM_WIDTH-1:0]  mem_rdata;
    logic [WORD_WIDTH-1:0] sourceID;
    logic [WORD_WIDTH-1:0] destinationID;
    logic [WORD_WIDTH-1:0] pkt_length;
    logic                  done;
    logic                  err;

    modport master (
        output start, base_addr, mem_rdata,
        input  mem_addr, mem_rd_en, sourceID, destinationID, pkt_length, done, err
    );

    modport slave (
        input  start, base_addr, mem_rdata,
        output mem_addr, mem_rd_en, sourceID, destinationID, pkt_length, done, err
    );

endinterface

// File: rtl/pkt_header_parser_hdr_word_assembler.sv
// Shifts returned header bytes into the big-endian word registers and flags a bad header.
// With PKT_HDR_CHECKSUM_EN a running XOR over all header bytes must fold to zero.
module hdr_word_assembler
    import pkt_defs_pkg::*;
(
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  cap_vld,
    input  logic [IDX_WIDTH-1:0]  cap_idx,
    input  logic [MEM_WIDTH-1:0]  cap_byte,
    output logic [WORD_WIDTH-1:0] source_id,
    output logic [WORD_WIDTH-1:0] dest_id,
    output logic [WORD_WIDTH-1:0] pkt_len,
    output logic                  hdr_bad
);

    logic [WORD_WIDTH-1:0] src_r, dst_r, len_r;
    logic [WORD_WIDTH-1:0] src_nxt_s, dst_nxt_s, len_nxt_s;
    logic                  len_bad_s;

    // Route the byte being captured into the field its index belongs to
    always_comb begin
        src_nxt_s = src_r;
        dst_nxt_s = dst_r;
        len_nxt_s = len_r;
        if (cap_vld) begin
            case (cap_idx)
                SRC_OFS, SRC_OFS + 3'd1: src_nxt_s = {src_r[WORD_WIDTH-MEM_WIDTH-1:0], cap_byte};
                DST_OFS, DST_OFS + 3'd1: dst_nxt_s = {dst_r[WORD_WIDTH-MEM_WIDTH-1:0], cap_byte};
                LEN_OFS, LEN_OFS + 3'd1: len_nxt_s = {len_r[WORD_WIDTH-MEM_WIDTH-1:0], cap_byte};
                default: begin
                    src_nxt_s = src_r;
                    dst_nxt_s = dst_r;
                    len_nxt_s = len_r;
                end
            endcase
        end else begin
            src_nxt_s = src_r;
            dst_nxt_s = dst_r;
            len_nxt_s = len_r;
        end
    end

    // Header word registers, cleared when a new parse begins
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            src_r <= {WORD_WIDTH{1'b0}};
            dst_r <= {WORD_WIDTH{1'b0}};
            len_r <= {WORD_WIDTH{1'b0}};
        end else if (clear) begin
            src_r <= {WORD_WIDTH{1'b0}};
            dst_r <= {WORD_WIDTH{1'b0}};
            len_r <= {WORD_WIDTH{1'b0}};
        end else begin
            src_r <= src_nxt_s;
            dst_r <= dst_nxt_s;
            len_r <= len_nxt_s;
        end
    end

    // Evaluated against the next-state length so the verdict covers the final byte
    assign len_bad_s = len_invalid(len_nxt_s);

`ifdef PKT_HDR_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum_r, csum_nxt_s;

    // Running XOR of every header byte, checksum bytes included
    always_comb begin
        csum_nxt_s = csum_r;
        if (cap_vld) begin
            csum_nxt_s = csum_fold(csum_r, cap_byte, cap_idx[0]);
        end else begin
            csum_nxt_s = csum_r;
        end
    end

    // Checksum accumulator register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            csum_r <= {WORD_WIDTH{1'b0}};
        end else if (clear) begin
            csum_r <= {WORD_WIDTH{1'b0}};
        end else begin
            csum_r <= csum_nxt_s;
        end
    end

    assign hdr_bad = len_bad_s || (csum_nxt_s != {WORD_WIDTH{1'b0}});
`else
    assign hdr_bad = len_bad_s;
`endif

    assign source_id = src_r;
    assign dest_id   = dst_r;
    assign pkt_len   = len_r;

endmodule

// File: rtl/pkt_header_parser.sv
// Reads a big-endian packet header from packet memory and presents its fields with done/err.
// Build option PKT_HDR_CHECKSUM_EN adds an 8-byte header with checksum verification.
module pkt_header_parser
    import pkt_defs_pkg::*;
(
    input  logic               clock,
    input  logic               rst,
    pkt_header_parser_if.slave bus
);

    state_e                state_r, state_nxt_s;
    logic [IDX_WIDTH-1:0]  cnt_r, cap_idx_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  mem_rd_en_r, cap_vld_r, done_r, err_r;
    logic                  parse_go_s, hdr_bad_s;
    logic [WORD_WIDTH-1:0] src_s, dst_s, len_s;

    assign parse_go_s = (state_r == ST_IDLE) && bus.start;

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nxt_s = ST_READ;
                else           state_nxt_s = ST_IDLE;
            end
            ST_READ: begin
                if (cnt_r == LAST_IDX) state_nxt_s = ST_DRAIN;
                else                   state_nxt_s = ST_READ;
            end
            ST_DRAIN: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (!bus.start) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read issue, capture pipeline and handshake registers; capture trails issue by one cycle
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_rd_en_r <= 1'b0;
            cnt_r       <= {IDX_WIDTH{1'b0}};
            cap_vld_r   <= 1'b0;
            cap_idx_r   <= {IDX_WIDTH{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            mem_rd_en_r <= (state_nxt_s == ST_READ);
            cap_vld_r   <= mem_rd_en_r;
            cap_idx_r   <= cnt_r;
            done_r      <= (state_nxt_s == ST_DONE);
            if (parse_go_s) begin
                mem_addr_r <= bus.base_addr;
                cnt_r      <= {IDX_WIDTH{1'b0}};
                err_r      <= 1'b0;
            end else if (state_r == ST_READ) begin
                mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1'b1);
                cnt_r      <= cnt_r + IDX_WIDTH'(1'b1);
            end else if (state_r == ST_DRAIN) begin
                err_r <= hdr_bad_s;
            end else begin
                mem_addr_r <= mem_addr_r;
                cnt_r      <= cnt_r;
            end
        end
    end

    hdr_word_assembler u_asm (
        .clock     (clock),
        .rst       (rst),
        .clear     (parse_go_s),
        .cap_vld   (cap_vld_r),
        .cap_idx   (cap_idx_r),
        .cap_byte  (bus.mem_rdata),
        .source_id (src_s),
        .dest_id   (dst_s),
        .pkt_len   (len_s),
        .hdr_bad   (hdr_bad_s)
    );

    assign bus.mem_addr      = mem_addr_r;
    assign bus.mem_rd_en     = mem_rd_en_r;
    assign bus.sourceID      = src_s;
    assign bus.destinationID = dst_s;
    assign bus.pkt_length    = len_s;
    assign bus.done          = done_r;
    assign bus.err           = err_r;

endmodule

// File: tb/tb_pkt_header_parser.sv
// Randomised scoreboard bench for pkt_header_parser: a reference model predicts fields, err and read addresses.
module tb_pkt_header_parser;
    import pkt_defs_pkg::*;

`ifdef PKT_HDR_CHECKSUM_EN
    localparam int HB = 8;
`else
    localparam int HB = 6;
`endif

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    logic rst;
    logic [7:0] mem [0:1023];
    exp_t exp_q[$];
    int   addr_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic done_q   = 1'b0;

    pkt_header_parser_if bus();

    pkt_header_parser dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Synchronous-read packet memory
    always @(posedge clock) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write_hdr(input int base, input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] l, input logic [15:0] c);
        logic [7:0] b [8];
        logic [9:0] a;
        b = '{s[15:8], s[7:0], d[15:8], d[7:0], l[15:8], l[7:0], c[15:8], c[7:0]};
        for (int i = 0; i < 8; i++) begin
            a = 10'(base + i);
            mem[a] = b[i];
        end
    endtask

    // Reference model: header decoded straight from memory contents
    task automatic issue_expect(input int base);
        logic [7:0] b [8];
        logic [9:0] a;
        exp_t e;
        for (int i = 0; i < HB; i++) begin
            a = 10'(base + i);
            b[i] = mem[a];
            addr_q.push_back(int'(a));
        end
        e.src = {b[0], b[1]};
        e.dst = {b[2], b[3]};
        e.len = {b[4], b[5]};
        e.err = (e.len == 16'd0) || (int'(e.len) > 1024);
`ifdef PKT_HDR_CHECKSUM_EN
        if ({b[6], b[7]} != (e.src ^ e.dst ^ e.len)) e.err = 1'b1;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: compares every read address and every done rising edge against the queues
    always @(negedge clock) begin
        if (!rst) begin
            if (bus.mem_rd_en) begin
                if (addr_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
                else check("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
            end
            if (bus.done && !done_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sourceID",      32'(bus.sourceID),      32'(e.src));
                    check("destinationID", 32'(bus.destinationID), 32'(e.dst));
                    check("pkt_length",    32'(bus.pkt_length),    32'(e.len));
                    check("err",           32'(bus.err),           32'(e.err));
                end
            end
        end
        done_q <= bus.done;
    end

    // mode 0: start held 10 cycles past done; 1: one-cycle pulse; 2: start dropped mid-parse
    task automatic run_parse(input int base, input int mode);
        int   cycles;
        logic got;
        @(negedge clock);
        issue_expect(base);
        bus.base_addr = 10'(base);
        bus.start     = 1'b1;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clock);
            cycles++;
            if (cycles == 1) begin
                #1 bus.base_addr = 10'($urandom_range(0, 1023));
                if (mode == 1) bus.start = 1'b0;
            end
            if (mode == 2 && cycles == 3) #1 bus.start = 1'b0;
            @(negedge clock);
            got = bus.done;
        end
        check("done_latency", 32'(cycles), 32'(HB + 2));
        if (mode == 0) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                check("done_held", 32'(bus.done), 32'd1);
                check("no_reread", 32'(bus.mem_rd_en), 32'd0);
            end
            bus.start = 1'b0;
            @(negedge clock);
            check("done_drop", 32'(bus.done), 32'd0);
        end else begin
            bus.start = 1'b0;
            @(negedge clock);
            check("done_one_cycle", 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] s, d, l, c;
        int          base, sel;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = 10'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clock);
        check("rst_done",     32'(bus.done),          32'd0);
        check("rst_err",      32'(bus.err),           32'd0);
        check("rst_rd_en",    32'(bus.mem_rd_en),     32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr),      32'd0);
        check("rst_src",      32'(bus.sourceID),      32'd0);
        check("rst_dst",      32'(bus.destinationID), 32'd0);
        check("rst_len",      32'(bus.pkt_length),    32'd0);
        rst = 1'b0;
        @(negedge clock);

        // Basic header with literal expectations after start is dropped
        write_hdr(16'h010, 16'h0005, 16'h002A, 16'h0040, 16'h006F);
        run_parse(16'h010, 0);
        check("basic_src", 32'(bus.sourceID),      32'h0005);
        check("basic_dst", 32'(bus.destinationID), 32'h002A);
        check("basic_len", 32'(bus.pkt_length),    32'h0040);
        check("basic_err", 32'(bus.err),           32'd0);

        // Address wrap-around
        write_hdr(16'h3FD, 16'hA1B2, 16'hC3D4, 16'h0123, 16'hA1B2 ^ 16'hC3D4 ^ 16'h0123);
        run_parse(16'h3FD, 1);

        // Length boundaries: 0, 1025, 1024, 1
        write_hdr(16'h200, 16'h1111, 16'h2222, 16'h0000, 16'h1111 ^ 16'h2222);
        run_parse(16'h200, 0);
        write_hdr(16'h208, 16'h1111, 16'h2222, 16'h0401, 16'h1111 ^ 16'h2222 ^ 16'h0401);
        run_parse(16'h208, 1);
        write_hdr(16'h210, 16'h1111, 16'h2222, 16'h0400, 16'h1111 ^ 16'h2222 ^ 16'h0400);
        run_parse(16'h210, 2);
        write_hdr(16'h218, 16'h1111, 16'h2222, 16'h0001, 16'h1111 ^ 16'h2222 ^ 16'h0001);
        run_parse(16'h218, 1);

        // Wrong checksum bytes (only rejected when the checksum is part of the header)
        write_hdr(16'h100, 16'h0005, 16'h002A, 16'h0040, 16'h006E);
        run_parse(16'h100, 2);

        // Reset during the third read cycle
        write_hdr(16'h050, 16'h1234, 16'h5678, 16'h0010, 16'h1234 ^ 16'h5678 ^ 16'h0010);
        @(negedge clock);
        issue_expect(16'h050);
        bus.base_addr = 10'h050;
        bus.start     = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        check("pre_rst_rd_en", 32'(bus.mem_rd_en), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(bus.mem_rd_en),     32'd0);
        check("mid_rst_done",  32'(bus.done),          32'd0);
        check("mid_rst_src",   32'(bus.sourceID),      32'd0);
        check("mid_rst_dst",   32'(bus.destinationID), 32'd0);
        check("mid_rst_len",   32'(bus.pkt_length),    32'd0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clock);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("post_rst_idle_done", 32'(bus.done),      32'd0);
            check("post_rst_idle_rd",   32'(bus.mem_rd_en), 32'd0);
        end

        // Randomised headers, bases and handshake modes
        for (int n = 0; n < 30; n++) begin
            base = $urandom_range(0, 1023);
            s    = 16'($urandom);
            d    = 16'($urandom);
            sel  = $urandom_range(0, 3);
            if (sel == 0)      l = 16'($urandom);
            else if (sel == 1) l = 16'($urandom_range(1024, 1025));
            else               l = 16'($urandom_range(0, 1024));
            c = s ^ d ^ l;
            if ($urandom_range(0, 3) == 0) c = c ^ 16'($urandom_range(1, 65535));
            write_hdr(base, s, d, l, c);
            run_parse(base, $urandom_range(0, 2));
        end

        repeat (5) @(negedge clock);
        check("exp_q_empty",  32'(exp_q.size()),  32'd0);
        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
